sound_sequencer: RTL and testbench

//  Schedules game sound effects onto the single tone datapath (four note clock dividers + sine ROM).

---
 rtl/sound_pkg.sv | 32 +++
 rtl/sound_pattern_rom.sv | 37 +++
 rtl/sound_sequencer.sv | 141 ++++++++++++++
 tb/tb_sound_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared encodings for the sound sequencer.
// Covers note codes, event indices, FSM states and the event priority encoder.
package sound_pkg;

    localparam logic [2:0] NOTE_OFF = 3'b000;
    localparam logic [2:0] NOTE_DO  = 3'b001;
    localparam logic [2:0] NOTE_RE  = 3'b010;
    localparam logic [2:0] NOTE_MI  = 3'b011;
    localparam logic [2:0] NOTE_SOL = 3'b100;

    localparam logic [1:0] EV_PADDLE   = 2'd0;
    localparam logic [1:0] EV_WALL     = 2'd1;
    localparam logic [1:0] EV_BRICK    = 2'd2;
    localparam logic [1:0] EV_GAMEOVER = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Highest set index wins; the result is meaningless when req is zero.
    function automatic logic [1:0] pick_winner(input logic [3:0] req);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) w = 2'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/sound_pattern_rom.sv
// Note pattern table: (event, step) -> note code and whether that step ends the pattern.
// Steps beyond a pattern's end read as silent and final.
module sound_pattern_rom
    import sound_pkg::*;
(
    input  logic [1:0] ev,
    input  logic [1:0] step,
    output logic [2:0] note,
    output logic       last
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        note = NOTE_OFF;
        last = 1'b1;
        case (ev)
            EV_PADDLE: if (step == 2'd0) note = NOTE_DO;
            EV_WALL:   if (step == 2'd0) note = NOTE_RE;
            EV_BRICK: begin
                case (step)
                    2'd0:    begin note = NOTE_MI;  last = 1'b0; end
                    2'd1:    note = NOTE_SOL;
                    default: note = NOTE_OFF;
                endcase
            end
            default: begin
                case (step)
                    2'd0:    begin note = NOTE_SOL; last = 1'b0; end
                    2'd1:    begin note = NOTE_MI;  last = 1'b0; end
                    2'd2:    begin note = NOTE_RE;  last = 1'b0; end
                    default: note = NOTE_DO;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sound_sequencer.sv
// Queues one-cycle sound event requests by fixed priority and plays each event's note
// pattern with fixed note and gap durations; game over preempts everything else.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int NOTE_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 500_000,
    parameter int CNT_W       = 23
) (
    input  logic       clk50mhz,
    input  logic       reset_button,
    input  logic [3:0] sound_req,
    output logic [2:0] note_sel,
    output logic       busy,
    output logic [1:0] cur_event,
    output logic [3:0] ack
);

    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [1:0]        step, step_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        pending, pending_nxt;
    logic              last_q, last_nxt;
    logic [2:0]        note_nxt;
    logic [1:0]        ev_nxt;
    logic [3:0]        ack_nxt;

    logic [3:0]        combined;
    logic [1:0]        winner;
    logic              preempt;
    logic              use_winner;
    logic [1:0]        load_ev, load_step;
    logic [2:0]        load_note;
    logic              load_last;
    logic              start, advance;

    assign combined = pending | sound_req;
    assign winner   = pick_winner(combined);
    assign preempt  = (state != IDLE) && (cur_event != EV_GAMEOVER) && combined[EV_GAMEOVER];
    assign busy     = (state != IDLE);

    // The ROM is addressed for whatever note could be loaded this cycle: the next step of
    // the current pattern while it still has one, otherwise step 0 of the priority winner.
    assign use_winner = preempt || !((state == GAP) && !last_q);
    assign load_ev    = use_winner ? winner : cur_event;
    assign load_step  = use_winner ? 2'd0 : step + 2'd1;

    sound_pattern_rom u_rom (
        .ev   (load_ev),
        .step (load_step),
        .note (load_note),
        .last (load_last)
    );

    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        cnt_nxt     = cnt;
        note_nxt    = note_sel;
        ev_nxt      = cur_event;
        last_nxt    = last_q;
        ack_nxt     = 4'b0000;
        pending_nxt = combined;
        start       = 1'b0;
        advance     = 1'b0;

        case (state)
            IDLE: start = (combined != 4'b0000);
            PLAY: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                    note_nxt  = NOTE_OFF;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (cnt == '0) begin
                    if (!last_q) begin
                        advance = 1'b1;
                    end else if (combined != 4'b0000) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        note_nxt  = NOTE_OFF;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start || advance) begin
            state_nxt = PLAY;
            cnt_nxt   = NOTE_LOAD;
            note_nxt  = load_note;
            last_nxt  = load_last;
            step_nxt  = start ? 2'd0 : step + 2'd1;
        end

        // A started event leaves the queue; a preempted one is simply overwritten.
        if (start) begin
            ev_nxt      = winner;
            ack_nxt     = 4'b0001 << winner;
            pending_nxt = combined & ~(4'b0001 << winner);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, with an asynchronous clear.
    always_ff @(posedge clk50mhz or negedge reset_button) begin
        if (!reset_button) begin
            state     <= IDLE;
            step      <= 2'd0;
            cnt       <= '0;
            pending   <= 4'b0000;
            last_q    <= 1'b1;
            note_sel  <= NOTE_OFF;
            cur_event <= EV_PADDLE;
            ack       <= 4'b0000;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            cnt       <= cnt_nxt;
            pending   <= pending_nxt;
            last_q    <= last_nxt;
            note_sel  <= note_nxt;
            cur_event <= ev_nxt;
            ack       <= ack_nxt;
        end
    end

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: directed scenarios plus random requests,
// compared every cycle against a queue-based behavioural model of the sequencer.
module tb_sound_sequencer;

    localparam int NOTE_CYCLES = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int CNT_W       = 3;

    logic       clk50mhz = 1'b0;
    logic       reset_button = 1'b0;
    logic [3:0] sound_req = 4'b0000;
    logic [2:0] note_sel;
    logic       busy;
    logic [1:0] cur_event;
    logic [3:0] ack;

    sound_sequencer #(
        .NOTE_CYCLES (NOTE_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk50mhz     (clk50mhz),
        .reset_button (reset_button),
        .sound_req    (sound_req),
        .note_sel     (note_sel),
        .busy         (busy),
        .cur_event    (cur_event),
        .ack          (ack)
    );

    always #5 clk50mhz = ~clk50mhz;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: pending set, remaining notes of the pattern, cycles left in segment.
    logic [3:0] m_pend;
    logic       m_play;
    logic       m_gap;
    logic [1:0] m_ev;
    logic [2:0] m_note;
    logic [3:0] m_ack;
    int         m_left;
    logic [2:0] m_q[$];

    function automatic int pat_len(input int ev);
        case (ev)
            2:       return 2;
            3:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] pat_note(input int ev, input int i);
        case (ev)
            0:       return 3'd1;
            1:       return 3'd2;
            2:       return (i == 0) ? 3'd3 : 3'd4;
            default: return 3'(4 - i);
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 4'b0000;
        m_play = 1'b0;
        m_gap  = 1'b0;
        m_ev   = 2'd0;
        m_note = 3'd0;
        m_ack  = 4'b0000;
        m_left = 0;
        m_q.delete();
    endtask

    task automatic model_start(input logic [3:0] comb);
        int w;
        w = 0;
        for (int i = 0; i < 4; i++) if (comb[i]) w = i;
        m_ev = 2'(w);
        m_q.delete();
        for (int i = 0; i < pat_len(w); i++) m_q.push_back(pat_note(w, i));
        m_note = m_q.pop_front();
        m_left = NOTE_CYCLES;
        m_gap  = 1'b0;
        m_play = 1'b1;
        m_ack  = 4'b0001 << w;
        m_pend = comb & ~(4'b0001 << w);
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] comb;
        comb   = m_pend | r;
        m_pend = comb;
        m_ack  = 4'b0000;
        if (!m_play) begin
            if (comb != 4'b0000) model_start(comb);
        end else if (m_ev != 2'd3 && comb[3]) begin
            model_start(comb);
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (!m_gap) begin
                    m_gap  = 1'b1;
                    m_left = GAP_CYCLES;
                    m_note = 3'd0;
                end else if (m_q.size() > 0) begin
                    m_note = m_q.pop_front();
                    m_left = NOTE_CYCLES;
                    m_gap  = 1'b0;
                end else if (comb != 4'b0000) begin
                    model_start(comb);
                end else begin
                    m_play = 1'b0;
                    m_note = 3'd0;
                end
            end
        end
    endtask

    // One clock: apply request, advance model at the edge, compare on the falling edge.
    task automatic cycle(input logic [3:0] r, input string tag);
        sound_req = r;
        @(posedge clk50mhz);
        model_step(r);
        @(negedge clk50mhz);
        ack_cnt += $countones(ack);
        check(tag, {note_sel, busy, cur_event, ack}, {m_note, m_play, m_ev, m_ack});
        sound_req = 4'b0000;
    endtask

    task automatic idle_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(4'b0000, tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk50mhz);
        check("reset_note", note_sel, 3'b000);
        check("reset_busy", busy, 1'b0);
        check("reset_event", cur_event, 2'b00);
        check("reset_ack", ack, 4'b0000);
        reset_button = 1'b1;
        @(negedge clk50mhz);

        // Single paddle hit
        ack_cnt = 0;
        cycle(4'b0001, "t1_start");
        check("t1_note_now", note_sel, 3'b001);
        check("t1_ack_now", ack, 4'b0001);
        idle_n(6, "t1_run");
        check("t1_busy_done", busy, 1'b0);
        check("t1_acks", ack_cnt, 1);

        // Brick: two-note pattern
        ack_cnt = 0;
        cycle(4'b0100, "t2_start");
        idle_n(13, "t2_run");
        check("t2_busy_done", busy, 1'b0);
        check("t2_acks", ack_cnt, 1);

        // Wall and paddle together
        ack_cnt = 0;
        cycle(4'b0011, "t3_start");
        check("t3_first_note", note_sel, 3'b010);
        idle_n(14, "t3_run");
        check("t3_acks", ack_cnt, 2);

        // Game over preempts brick
        ack_cnt = 0;
        cycle(4'b0100, "t4_start");
        idle_n(2, "t4_brick");
        cycle(4'b1000, "t4_preempt");
        check("t4_go_note", note_sel, 3'b100);
        check("t4_go_ack", ack, 4'b1000);
        idle_n(25, "t4_run");
        check("t4_busy_done", busy, 1'b0);
        check("t4_acks", ack_cnt, 2);

        // Asynchronous reset mid-note with paddle pending
        cycle(4'b0100, "t5_start");
        cycle(4'b0001, "t5_pend");
        #2;
        reset_button = 1'b0;
        #1;
        check("t5_rst_note", note_sel, 3'b000);
        check("t5_rst_busy", busy, 1'b0);
        model_reset();
        @(negedge clk50mhz);
        reset_button = 1'b1;
        idle_n(10, "t5_after");
        check("t5_stays_idle", busy, 1'b0);

        // Paddle re-requested twice while playing
        ack_cnt = 0;
        cycle(4'b0001, "t6_start");
        cycle(4'b0000, "t6_run");
        cycle(4'b0001, "t6_req2");
        cycle(4'b0000, "t6_run");
        cycle(4'b0001, "t6_req3");
        idle_n(20, "t6_run");
        check("t6_acks", ack_cnt, 2);

        // Random request traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 19) == 0);
            cycle(r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
